dmem_ram_bridge: RTL and testbench

//  Bridges the core's dcache cmd/rsp port to a RAMHelper-style 64-bit word memory in the sim top.

---
 rtl/dmem_ram_bridge_pkg.sv | 31 +++
 rtl/dmem_ram_bridge_if.sv | 29 ++
 rtl/dmem_ram_bridge.sv | 137 +++++++++++++
 tb/tb_dmem_ram_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ram_bridge_pkg.sv
// dmem_pkg: shared definitions for the dcache-to-RAMHelper bridge.
//   SZ_B/SZ_H/SZ_W/SZ_D - cmd_size encodings (byte, half, word, double)
//   state_e             - bridge FSM states
//   RAM_BASE            - default byte address of RAM word 0
//   strb_to_mask()      - expands an 8-bit byte strobe into a 64-bit bit mask
package dmem_pkg;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  localparam logic [63:0] RAM_BASE = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_ram_bridge_if.sv
// dmem_ram_bridge_if: dcache cmd/rsp port between the core and the bridge.
//   cmd_valid/cmd_ready          request handshake
//   cmd_addr/wen/wdata/wstrb/size request fields (byte address, store flag, data, strobes, size)
//   rsp_valid/rsp_data/rsp_error one-cycle response pulse with data and error flag
// master: core side; slave: bridge side.
interface dmem_ram_bridge_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_addr;
  logic        cmd_wen;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic [2:0]  cmd_size;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_error;

  modport master (
    output cmd_valid, cmd_addr, cmd_wen, cmd_wdata, cmd_wstrb, cmd_size,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_wen, cmd_wdata, cmd_wstrb, cmd_size,
    output cmd_ready, rsp_valid, rsp_data, rsp_error
  );

endinterface

// File: rtl/dmem_ram_bridge.sv
// dmem_ram_bridge: one-outstanding-request bridge from the dcache cmd/rsp port
// to a 64-bit word RAM. Checks size, alignment and address window, inserts
// LATENCY wait cycles, then performs a single word access and a response pulse.
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   bus                  dcache cmd/rsp port (slave side)
//   ram_en, ram_idx      RAM access strobe and word index (rIdx and wIdx)
//   ram_rdata            RAM read data, combinational on ram_idx while ram_en
//   ram_wdata, ram_wmask RAM write data and bit mask
//   ram_wen              RAM write enable
//
// state     | meaning
// ST_IDLE   | ready; latch request and its error flag on cmd_valid
// ST_WAIT   | burning LATENCY wait cycles (cnt counts down to 0)
// ST_ACCESS | single RAM access cycle; read data captured at the edge
// ST_RESP   | response pulse (loads, errors, and stores if RSP_ON_STORE)
module dmem_ram_bridge
  import dmem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR    = RAM_BASE,
  parameter int unsigned IDX_W        = 28,
  parameter int unsigned LATENCY      = 0,
  parameter bit          RSP_ON_STORE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  dmem_ram_bridge_if.slave bus,
  output logic             ram_en,
  output logic [IDX_W-1:0] ram_idx,
  input  logic [63:0]      ram_rdata,
  output logic [63:0]      ram_wdata,
  output logic [63:0]      ram_wmask,
  output logic             ram_wen
);

  localparam int unsigned WIN_SHIFT = IDX_W + 3;
  localparam logic [3:0]  WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             wen_q;
  logic             err_q;
  logic [63:0]      wdata_q;
  logic [7:0]       wstrb_q;
  logic [63:0]      rdata_q;

  logic [63:0]      offset;
  logic             misaligned;
  logic             out_of_range;
  logic             cmd_err;
  logic             accept;

  // Request checks; the offset is taken modulo 2^64, so an address below the
  // base is caught by the explicit compare rather than by the window test.
  always_comb begin
    offset     = bus.cmd_addr - BASE_ADDR;
    misaligned = 1'b0;
    case (bus.cmd_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = bus.cmd_addr[0];
      SZ_W:    misaligned = |bus.cmd_addr[1:0];
      SZ_D:    misaligned = |bus.cmd_addr[2:0];
      default: misaligned = 1'b1;  // illegal size folds into the same error
    endcase
    out_of_range = (bus.cmd_addr < BASE_ADDR) || ((offset >> WIN_SHIFT) != 64'd0);
    cmd_err      = misaligned || out_of_range;
  end

  assign accept = (state_q == ST_IDLE) && bus.cmd_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (LATENCY == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= offset[IDX_W+2:3];
        wen_q   <= bus.cmd_wen;
        err_q   <= cmd_err;
        wdata_q <= bus.cmd_wdata;
        wstrb_q <= bus.cmd_wstrb;
      end
      if (state_q == ST_ACCESS) begin
        rdata_q <= err_q ? 64'd0 : ram_rdata;
      end
    end
  end

  // All outputs come from registered state/fields only.
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP) && (err_q || !wen_q || RSP_ON_STORE);
  assign bus.rsp_error = (state_q == ST_RESP) && err_q;
  assign bus.rsp_data  = rdata_q;

  assign ram_en    = (state_q == ST_ACCESS) && !err_q;
  assign ram_wen   = (state_q == ST_ACCESS) && wen_q && !err_q;
  assign ram_idx   = idx_q;
  assign ram_wdata = wdata_q;
  assign ram_wmask = strb_to_mask(wstrb_q);

endmodule

// File: tb/tb_dmem_ram_bridge.sv
module tb_dmem_ram_bridge;

  localparam int IDX_W = 28;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset0, reset1, sel;
  logic        cmd_valid, cmd_wen;
  logic [63:0] cmd_addr, cmd_wdata, ram_rdata;
  logic [7:0]  cmd_wstrb;
  logic [2:0]  cmd_size;

  logic             en0, wen0, en1, wen1;
  logic [IDX_W-1:0] idx0, idx1;
  logic [63:0]      wdata0, wmask0, wdata1, wmask1;

  dmem_ram_bridge_if bus0();
  dmem_ram_bridge_if bus1();

  assign bus0.cmd_valid = cmd_valid & ~sel;
  assign bus0.cmd_addr  = cmd_addr;
  assign bus0.cmd_wen   = cmd_wen;
  assign bus0.cmd_wdata = cmd_wdata;
  assign bus0.cmd_wstrb = cmd_wstrb;
  assign bus0.cmd_size  = cmd_size;
  assign bus1.cmd_valid = cmd_valid & sel;
  assign bus1.cmd_addr  = cmd_addr;
  assign bus1.cmd_wen   = cmd_wen;
  assign bus1.cmd_wdata = cmd_wdata;
  assign bus1.cmd_wstrb = cmd_wstrb;
  assign bus1.cmd_size  = cmd_size;

  dmem_ram_bridge #(.BASE_ADDR(BASE), .IDX_W(IDX_W), .LATENCY(0), .RSP_ON_STORE(1'b0)) dut0 (
    .clock(clock), .reset(reset0), .bus(bus0),
    .ram_en(en0), .ram_idx(idx0), .ram_rdata(ram_rdata),
    .ram_wdata(wdata0), .ram_wmask(wmask0), .ram_wen(wen0)
  );

  dmem_ram_bridge #(.BASE_ADDR(BASE), .IDX_W(IDX_W), .LATENCY(3), .RSP_ON_STORE(1'b1)) dut1 (
    .clock(clock), .reset(reset1), .bus(bus1),
    .ram_en(en1), .ram_idx(idx1), .ram_rdata(ram_rdata),
    .ram_wdata(wdata1), .ram_wmask(wmask1), .ram_wen(wen1)
  );

  // Observation mux: sel picks which bridge the current task is watching.
  logic             obs_ready, obs_rsp_valid, obs_rsp_error, obs_en, obs_wen;
  logic [63:0]      obs_rsp_data, obs_wdata, obs_wmask;
  logic [IDX_W-1:0] obs_idx;
  always_comb begin
    obs_ready     = sel ? bus1.cmd_ready : bus0.cmd_ready;
    obs_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
    obs_rsp_error = sel ? bus1.rsp_error : bus0.rsp_error;
    obs_rsp_data  = sel ? bus1.rsp_data  : bus0.rsp_data;
    obs_en        = sel ? en1    : en0;
    obs_wen       = sel ? wen1   : wen0;
    obs_idx       = sel ? idx1   : idx0;
    obs_wdata     = sel ? wdata1 : wdata0;
    obs_wmask     = sel ? wmask1 : wmask0;
  end

  typedef struct {
    logic        err;
    logic [63:0] data;
  } rsp_exp_t;

  rsp_exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit model_err(input logic [63:0] addr, input logic [2:0] size);
    logic [63:0] align;
    if (size > 3'd3) return 1'b1;
    align = 64'd1 << size;
    if ((addr % align) != 64'd0) return 1'b1;
    if (addr < BASE) return 1'b1;
    if ((addr - BASE) >= (64'd1 << (IDX_W + 3))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset;
    sel = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wen = 1'b0;
    cmd_wdata = '0; cmd_wstrb = '0; cmd_size = '0; ram_rdata = '0;
    reset0 = 1'b1; reset1 = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset0 = 1'b0; reset1 = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clock);
      sel = s[0];
      #1;
      n_cmp++; if (obs_ready !== 1'b1)      begin n_bad++; $display("FAIL reset_ready dut%0d got %b exp 1", s, obs_ready); end
      n_cmp++; if (obs_rsp_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_rsp_valid dut%0d got %b exp 0", s, obs_rsp_valid); end
      n_cmp++; if (obs_rsp_error !== 1'b0)  begin n_bad++; $display("FAIL reset_rsp_error dut%0d got %b exp 0", s, obs_rsp_error); end
      n_cmp++; if (obs_rsp_data !== 64'd0)  begin n_bad++; $display("FAIL reset_rsp_data dut%0d got %h exp 0", s, obs_rsp_data); end
      n_cmp++; if (obs_en !== 1'b0)         begin n_bad++; $display("FAIL reset_ram_en dut%0d got %b exp 0", s, obs_en); end
      n_cmp++; if (obs_wen !== 1'b0)        begin n_bad++; $display("FAIL reset_ram_wen dut%0d got %b exp 0", s, obs_wen); end
    end
  endtask

  // One request on the selected bridge, cmd_valid dropped right after accept.
  task automatic run_op(input bit s, input logic [63:0] addr, input bit wen,
                        input logic [63:0] wdata, input logic [7:0] wstrb,
                        input logic [2:0] size, input logic [63:0] rdata, input string name);
    int lat;
    int ready_lo;
    bit err, exp_rsp;
    logic [IDX_W-1:0] exp_idx;
    logic [63:0] exp_mask, off;
    rsp_exp_t e;
    lat = s ? 3 : 0;
    err = model_err(addr, size);
    exp_rsp = err || !wen || s;
    off = addr - BASE;
    exp_idx = off[IDX_W+2:3];
    for (int i = 0; i < 8; i++) exp_mask[i*8 +: 8] = wstrb[i] ? 8'hFF : 8'h00;
    ready_lo = 0;

    @(negedge clock);
    sel = s;
    #1;
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL %s ready_before got %b exp 1", name, obs_ready); end
    cmd_addr = addr; cmd_wen = wen; cmd_wdata = wdata; cmd_wstrb = wstrb;
    cmd_size = size; ram_rdata = rdata; cmd_valid = 1'b1;
    if (exp_rsp) sb.push_back('{err: err, data: (err ? 64'd0 : rdata)});
    @(posedge clock);
    #1 cmd_valid = 1'b0;

    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clock);
      if (k <= lat + 2 && obs_ready !== 1'b1) ready_lo++;
      n_cmp++;
      if (obs_en !== ((k == lat + 1) && !err)) begin
        n_bad++; $display("FAIL %s ram_en k=%0d got %b exp %b", name, k, obs_en, ((k == lat + 1) && !err));
      end
      if (k == lat + 1) begin
        n_cmp++;
        if (obs_wen !== (wen && !err)) begin n_bad++; $display("FAIL %s ram_wen got %b exp %b", name, obs_wen, (wen && !err)); end
        if (!err) begin
          n_cmp++; if (obs_idx !== exp_idx) begin n_bad++; $display("FAIL %s ram_idx got %h exp %h", name, obs_idx, exp_idx); end
        end
        if (wen && !err) begin
          n_cmp++; if (obs_wmask !== exp_mask) begin n_bad++; $display("FAIL %s ram_wmask got %h exp %h", name, obs_wmask, exp_mask); end
          n_cmp++; if (obs_wdata !== wdata)    begin n_bad++; $display("FAIL %s ram_wdata got %h exp %h", name, obs_wdata, wdata); end
        end
      end
      n_cmp++;
      if (obs_rsp_valid !== (exp_rsp && (k == lat + 2))) begin
        n_bad++; $display("FAIL %s rsp_valid k=%0d got %b exp %b", name, k, obs_rsp_valid, (exp_rsp && (k == lat + 2)));
      end
      if (obs_rsp_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++; if (obs_rsp_error !== e.err) begin n_bad++; $display("FAIL %s rsp_error got %b exp %b", name, obs_rsp_error, e.err); end
        n_cmp++; if (obs_rsp_data !== e.data) begin n_bad++; $display("FAIL %s rsp_data got %h exp %h", name, obs_rsp_data, e.data); end
      end
    end
    n_cmp++; if (ready_lo != lat + 2) begin n_bad++; $display("FAIL %s ready_low_cycles got %0d exp %0d", name, ready_lo, lat + 2); end
    n_cmp++; if (obs_ready !== 1'b1)  begin n_bad++; $display("FAIL %s ready_after got %b exp 1", name, obs_ready); end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s missing_rsp got none exp %0d pending", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_load;
    run_op(1'b0, 64'h8000_0010, 1'b0, 64'd0, 8'h00, 3'd3, 64'hDEAD_BEEF_0123_4567, "load_d_lat0");
    run_op(1'b0, 64'h8000_0012, 1'b0, 64'd0, 8'h00, 3'd1, 64'h0102_0304_0506_0708, "load_h_lat0");
    run_op(1'b0, 64'hFFFF_FFF8, 1'b0, 64'd0, 8'h00, 3'd3, 64'hA5A5_5A5A_0F0F_F0F0, "load_last_word");
    run_op(1'b1, 64'h8000_0010, 1'b0, 64'd0, 8'h00, 3'd3, 64'hCAFE_F00D_1234_5678, "load_d_lat3");
  endtask

  task automatic test_store;
    run_op(1'b0, 64'h8000_0008, 1'b1, 64'h1111_2222, 8'h0F, 3'd3, 64'h7777_8888_9999_AAAA, "store_no_rsp");
    run_op(1'b1, 64'h8000_0008, 1'b1, 64'h1111_2222, 8'h0F, 3'd3, 64'h7777_8888_9999_AAAA, "store_rsp");
    run_op(1'b0, 64'h8000_0100, 1'b1, 64'hFFFF_0000_FFFF_0000, 8'h00, 3'd3, 64'd0, "store_strb0");
    run_op(1'b0, 64'h8000_0103, 1'b1, 64'h0000_0000_AB00_0000, 8'h08, 3'd0, 64'd0, "store_byte");
  endtask

  task automatic test_errors;
    run_op(1'b0, 64'h8000_0006, 1'b0, 64'd0, 8'h00, 3'd2, 64'h1234_5678_9ABC_DEF0, "misaligned_w");
    run_op(1'b0, 64'h7FFF_FFF8, 1'b1, 64'h55, 8'hFF, 3'd3, 64'h1, "below_base");
    run_op(1'b0, 64'h1_0000_0000, 1'b1, 64'h55, 8'hFF, 3'd3, 64'h1, "above_window");
    run_op(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 3'd5, 64'h2, "illegal_size");
    run_op(1'b1, 64'h8000_0001, 1'b1, 64'h55, 8'h03, 3'd1, 64'h3, "misaligned_h_lat3");
  endtask

  // cmd_valid held high on the LATENCY=3 bridge: two back-to-back loads.
  task automatic test_back_to_back;
    rsp_exp_t e;
    bit exp_ready, exp_rsp, exp_en;
    @(negedge clock);
    sel = 1'b1;
    #1;
    cmd_addr = 64'h8000_0020; cmd_wen = 1'b0; cmd_wdata = '0; cmd_wstrb = '0;
    cmd_size = 3'd3; ram_rdata = 64'h0BAD_C0DE_0000_0001; cmd_valid = 1'b1;
    sb.push_back('{err: 1'b0, data: 64'h0BAD_C0DE_0000_0001});
    sb.push_back('{err: 1'b0, data: 64'h0BAD_C0DE_0000_0001});
    @(posedge clock);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      exp_ready = (k == 6) || (k == 12);
      exp_rsp   = (k == 5) || (k == 11);
      exp_en    = (k == 4) || (k == 10);
      n_cmp++; if (obs_ready !== exp_ready)   begin n_bad++; $display("FAIL b2b ready k=%0d got %b exp %b", k, obs_ready, exp_ready); end
      n_cmp++; if (obs_rsp_valid !== exp_rsp) begin n_bad++; $display("FAIL b2b rsp_valid k=%0d got %b exp %b", k, obs_rsp_valid, exp_rsp); end
      n_cmp++; if (obs_en !== exp_en)         begin n_bad++; $display("FAIL b2b ram_en k=%0d got %b exp %b", k, obs_en, exp_en); end
      if (obs_rsp_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++; if (obs_rsp_data !== e.data) begin n_bad++; $display("FAIL b2b rsp_data got %h exp %h", obs_rsp_data, e.data); end
      end
      if (k == 7) cmd_valid = 1'b0;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL b2b missing_rsp got none exp %0d pending", sb.size());
      sb.delete();
    end
  endtask

  // Reset pulse while the LATENCY=3 bridge sits in WAIT.
  task automatic test_reset_mid;
    int en_seen, rsp_seen;
    en_seen = 0; rsp_seen = 0;
    @(negedge clock);
    sel = 1'b1;
    #1;
    cmd_addr = 64'h8000_0040; cmd_wen = 1'b0; cmd_size = 3'd3;
    ram_rdata = 64'h1357_9BDF_2468_ACE0; cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid in_wait_ready got %b exp 0", obs_ready); end
    reset1 = 1'b1;
    @(negedge clock);
    reset1 = 1'b0;
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid ready_after_reset got %b exp 1", obs_ready); end
    for (int k = 0; k < 8; k++) begin
      if (obs_en === 1'b1) en_seen++;
      if (obs_rsp_valid === 1'b1) rsp_seen++;
      @(negedge clock);
    end
    n_cmp++; if (en_seen != 0)  begin n_bad++; $display("FAIL rst_mid ram_en_seen got %0d exp 0", en_seen); end
    n_cmp++; if (rsp_seen != 0) begin n_bad++; $display("FAIL rst_mid rsp_valid_seen got %0d exp 0", rsp_seen); end
    run_op(1'b1, 64'h8000_0048, 1'b0, 64'd0, 8'h00, 3'd3, 64'h0FED_CBA9_8765_4321, "load_after_reset");
  endtask

  initial begin
    test_reset;
    test_load;
    test_store;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
